// File: rtl/carregador_instrucoes.sv
// Program loader: takes a {length, instructions, XOR checksum} byte frame and writes
// each instruction into instruction memory, holding the CPU in reset until a good load.
module carregador_instrucoes #(
  parameter int                     LARGURA_END   = 8,
  parameter int                     LARGURA_DADO  = 8,
  parameter logic [LARGURA_END-1:0] ENDERECO_BASE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iniciar,
  input  logic [LARGURA_DADO-1:0] byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    mem_we,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic [LARGURA_DADO-1:0] mem_dado,
  output logic                    cpu_rst_n,
  output logic                    pronto,
  output logic                    erro
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    TAMANHO  = 3'd1,
    DADOS    = 3'd2,
    CHECKSUM = 3'd3,
    FIM      = 3'd4,
    ERRO     = 3'd5
  } estado_t;

  estado_t                 estado;
  estado_t                 proximo;
  logic [LARGURA_END-1:0]  tamanho;
  logic [LARGURA_END-1:0]  indice;
  logic [LARGURA_DADO-1:0] soma;

  logic                    aceito;
  logic [LARGURA_END-1:0]  tamanho_in;
  logic [LARGURA_END-1:0]  indice_prox;
  logic                    pronto_para_byte;

  assign aceito      = byte_valid & byte_ready;
  assign tamanho_in  = LARGURA_END'(byte_in);
  assign indice_prox = indice + 1'b1;

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: begin
        if (iniciar) proximo = TAMANHO;
      end
      TAMANHO: begin
        if (aceito) proximo = (tamanho_in == '0) ? CHECKSUM : DADOS;
      end
      DADOS: begin
        // Length never exceeds 2^LARGURA_END-1, so indice_prox cannot wrap before matching.
        if (aceito && (indice_prox == tamanho)) proximo = CHECKSUM;
      end
      CHECKSUM: begin
        if (aceito) proximo = (byte_in == soma) ? FIM : ERRO;
      end
      FIM:     proximo = OCIOSO;
      ERRO:    proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // byte_ready is registered from the next state so it lines up with the state register.
  always_comb begin
    pronto_para_byte = 1'b0;
    case (proximo)
      TAMANHO, DADOS, CHECKSUM: pronto_para_byte = 1'b1;
      default:                  pronto_para_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      byte_ready <= 1'b0;
    end else begin
      estado     <= proximo;
      byte_ready <= pronto_para_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tamanho      <= '0;
      indice       <= '0;
      soma         <= '0;
      mem_we       <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      cpu_rst_n    <= 1'b0;
      pronto       <= 1'b0;
      erro         <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            pronto    <= 1'b0;
            erro      <= 1'b0;
            indice    <= '0;
            soma      <= '0;
            cpu_rst_n <= 1'b0;
          end
        end
        TAMANHO: begin
          if (aceito) tamanho <= tamanho_in;
        end
        DADOS: begin
          if (aceito) begin
            mem_we       <= 1'b1;
            mem_dado     <= byte_in;
            mem_endereco <= ENDERECO_BASE + indice;
            soma         <= soma ^ byte_in;
            indice       <= indice_prox;
          end
        end
        FIM: begin
          pronto    <= 1'b1;
          cpu_rst_n <= 1'b1;
        end
        ERRO: begin
          erro      <= 1'b1;
          cpu_rst_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Directed bench for carregador_instrucoes: two instances (base 0 and base FE) share the
// byte stream; a scoreboard queue holds expected memory writes with their expected cycle.
module tb_carregador_instrucoes;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar_a = 1'b0, iniciar_b = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;

  logic       byte_ready_a, mem_we_a, cpu_rst_n_a, pronto_a, erro_a;
  logic [7:0] mem_endereco_a, mem_dado_a;
  logic       byte_ready_b, mem_we_b, cpu_rst_n_b, pronto_b, erro_b;
  logic [7:0] mem_endereco_b, mem_dado_b;

  always #5 clk = ~clk;

  carregador_instrucoes #(.LARGURA_END(8), .LARGURA_DADO(8), .ENDERECO_BASE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_a), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_a), .mem_we(mem_we_a), .mem_endereco(mem_endereco_a),
    .mem_dado(mem_dado_a), .cpu_rst_n(cpu_rst_n_a), .pronto(pronto_a), .erro(erro_a)
  );

  carregador_instrucoes #(.LARGURA_END(8), .LARGURA_DADO(8), .ENDERECO_BASE(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_b), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_b), .mem_we(mem_we_b), .mem_endereco(mem_endereco_b),
    .mem_dado(mem_dado_b), .cpu_rst_n(cpu_rst_n_b), .pronto(pronto_b), .erro(erro_b)
  );

  typedef struct packed {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [31:0] c;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  logic [7:0]  base;
  logic        sel = 1'b0;
  logic [31:0] cyc = '0;
  int          compared = 0;
  int          mismatched = 0;

  logic rdy, pr, er, cr;
  assign rdy = sel ? byte_ready_b : byte_ready_a;
  assign pr  = sel ? pronto_b     : pronto_a;
  assign er  = sel ? erro_b       : erro_a;
  assign cr  = sel ? cpu_rst_n_b  : cpu_rst_n_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (mem_we_a || mem_we_b) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_write: observed a=%b b=%b addr %h/%h expected none",
               mem_we_a, mem_we_b, mem_endereco_a, mem_endereco_b);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_inst", {31'd0, mem_we_b}, {31'd0, e.s});
        chk("wr_addr", {24'd0, (e.s ? mem_endereco_b : mem_endereco_a)}, {24'd0, e.a});
        chk("wr_data", {24'd0, (e.s ? mem_dado_b : mem_dado_a)}, {24'd0, e.d});
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic start_load();
    if (sel) iniciar_b = 1'b1; else iniciar_a = 1'b1;
    @(negedge clk);
    iniciar_a = 1'b0;
    iniciar_b = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit is_data, input logic [7:0] addr);
    int n;
    wr_t e;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout: observed byte_ready=0 expected 1");
    end else if (is_data) begin
      e.s = sel; e.a = addr; e.d = b; e.c = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Sends the first n bytes of frame; gap inserts one idle cycle after every byte.
  task automatic send_frame(input int n, input bit gap);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i - 1);
      send(frame[i], (i > 0) && (i < frame.size() - 1), a);
      if (gap) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic ep, input logic ee, input logic ec);
    int n;
    n = 0;
    while (!(pr || er) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_pronto"}, {31'd0, pr}, {31'd0, ep});
    chk({tag, "_erro"}, {31'd0, er}, {31'd0, ee});
    chk({tag, "_cpu_rst_n"}, {31'd0, cr}, {31'd0, ec});
    chk({tag, "_ready_idle"}, {31'd0, rdy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready_a}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
    chk("rst_mem_endereco", {24'd0, mem_endereco_a}, 32'd0);
    chk("rst_mem_dado", {24'd0, mem_dado_a}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n_a}, 32'd0);
    chk("rst_pronto", {31'd0, pronto_a}, 32'd0);
    chk("rst_erro", {31'd0, erro_a}, 32'd0);
    chk("rst_b_ready", {31'd0, byte_ready_b}, 32'd0);

    // 2: good frame, back-to-back
    sel = 1'b0; base = 8'h00;
    start_load();
    chk("t2_ready_after_start", {31'd0, rdy}, 32'd1);
    frame = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD0};
    send_frame(5, 1'b0);
    wait_done("t2", 1'b1, 1'b0, 1'b1);

    // 3: bad checksum
    start_load();
    chk("t3_pronto_cleared", {31'd0, pr}, 32'd0);
    chk("t3_cpu_held", {31'd0, cr}, 32'd0);
    frame = '{8'h02, 8'h11, 8'h22, 8'h00};
    send_frame(4, 1'b0);
    wait_done("t3", 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_cpu_stays_held", {31'd0, cr}, 32'd0);

    // 4: empty program, then one byte with valid toggling
    start_load();
    chk("t4_erro_cleared", {31'd0, er}, 32'd0);
    frame = '{8'h00, 8'h00};
    send_frame(2, 1'b0);
    wait_done("t4a", 1'b1, 1'b0, 1'b1);
    start_load();
    chk("t4b_pronto_cleared", {31'd0, pr}, 32'd0);
    frame = '{8'h01, 8'hFF, 8'hFF};
    send_frame(3, 1'b1);
    wait_done("t4b", 1'b1, 1'b0, 1'b1);

    // 5: address wrap on the FE-based instance
    sel = 1'b1; base = 8'hFE;
    start_load();
    frame = '{8'h03, 8'h01, 8'h02, 8'h04, 8'h07};
    send_frame(5, 1'b0);
    wait_done("t5", 1'b1, 1'b0, 1'b1);

    // 6: reset after the 2nd data byte of a 5-byte frame, then a full load
    sel = 1'b0; base = 8'h00;
    start_load();
    frame = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h10};
    send_frame(3, 1'b0);
    byte_valid = 1'b1;
    byte_in    = 8'h30;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready_in_rst", {31'd0, byte_ready_a}, 32'd0);
    chk("t6_we_in_rst", {31'd0, mem_we_a}, 32'd0);
    chk("t6_pronto_in_rst", {31'd0, pronto_a}, 32'd0);
    chk("t6_cpu_in_rst", {31'd0, cpu_rst_n_a}, 32'd0);
    chk("t6_addr_in_rst", {24'd0, mem_endereco_a}, 32'd0);
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_ready_after_rst", {31'd0, byte_ready_a}, 32'd0);
    start_load();
    send_frame(7, 1'b0);
    wait_done("t6", 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
